// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MEM/WB writeback slice
// Holds load-type encodings, writeback-source selects and the register index width.
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sub-word load lane select, extension and alignment check
// Ports:
//   rdata      in   aligned word from data memory
//   offset     in   byte offset within the word (load address bits [1:0])
//   ld_type    in   LW/LH/LHU/LB/LBU encoding
//   data       out  extended load value
//   misaligned out  access does not fit its natural alignment
module load_extend
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [1:0]  byte_lane;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        // Big-endian puts byte offset 0 in the top lane, so the lane index is 3-offset.
        byte_lane = BIG_ENDIAN ? ~offset : offset;
        case (byte_lane)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        // Halfword at offset 0 is the upper half when big-endian, lower half otherwise.
        half_val = (offset[1] ^ BIG_ENDIAN) ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (ld_type)
            LD_LH: begin
                data       = {{(DATA_W-16){half_val[15]}}, half_val};
                misaligned = offset[0];
            end
            LD_LHU: begin
                data       = {{(DATA_W-16){1'b0}}, half_val};
                misaligned = offset[0];
            end
            LD_LB:  data = {{(DATA_W-8){byte_val[7]}}, byte_val};
            LD_LBU: data = {{(DATA_W-8){1'b0}}, byte_val};
            default: begin
                data       = rdata;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, writeback mux, decode bypass, retire counter
// Ports:
//   clk, rst                         clock; synchronous active-high reset
//   mem_*                            instruction leaving MEM (valid, rd, ALU result/address, load data, selects, link)
//   stall, flush                     either one turns this cycle's capture into a bubble
//   regWrite, rc, dc                 register file write port, valid the cycle after capture
//   id_ra/id_rb, id_da_raw/id_db_raw decode read indices and raw register file data
//   id_da, id_db                     decode operands with the in-flight write forwarded
//   wb_misaligned                    pulse for a dropped misaligned load
//   retire_cnt                       retired instruction count
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = mips_pkg::REG_AW,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_ld_type,
    input  logic [DATA_W-1:0] mem_pc_plus8,
    input  logic              stall,
    input  logic              flush,
    output logic              regWrite,
    output logic [REG_AW-1:0] rc,
    output logic [DATA_W-1:0] dc,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic [DATA_W-1:0] id_da_raw,
    input  logic [DATA_W-1:0] id_db_raw,
    output logic [DATA_W-1:0] id_da,
    output logic [DATA_W-1:0] id_db,
    output logic              wb_misaligned,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [DATA_W-1:0] ld_data;
    logic              ld_misaligned;
    logic [DATA_W-1:0] wb_data_next;
    logic              capture;
    logic              is_load;
    logic              wb_valid;
    logic              wb_reg_write;

    load_extend #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_load_extend (
        .rdata      (mem_rdata),
        .offset     (mem_alu_result[1:0]),
        .ld_type    (mem_ld_type),
        .data       (ld_data),
        .misaligned (ld_misaligned)
    );

    assign capture = mem_valid & ~stall & ~flush;
    assign is_load = (mem_wb_sel == WB_SEL_LOAD);

    // Select 11 is unused and falls back to the ALU result.
    always_comb begin
        wb_data_next = mem_alu_result;
        case (mem_wb_sel)
            WB_SEL_LOAD: wb_data_next = ld_data;
            WB_SEL_LINK: wb_data_next = mem_pc_plus8;
            default:     wb_data_next = mem_alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
            rc            <= '0;
            dc            <= '0;
            retire_cnt    <= '0;
        end else begin
            // The instruction currently in WB retires as it leaves the stage.
            if (wb_valid && !wb_misaligned) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            wb_valid      <= capture;
            wb_misaligned <= capture & is_load & ld_misaligned;
            // Bubbles leave rc/dc untouched so the write port does not toggle.
            if (capture) begin
                wb_reg_write <= mem_reg_write;
                rc           <= mem_rd;
                dc           <= wb_data_next;
            end
        end
    end

    assign regWrite = wb_valid & wb_reg_write & (rc != '0) & ~wb_misaligned;

    // regWrite already excludes rc=0, so $0 is never forwarded.
    assign id_da = (regWrite && (rc == id_ra)) ? dc : id_da_raw;
    assign id_db = (regWrite && (rc == id_rb)) ? dc : id_db_raw;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_ld_type;
    logic [31:0] mem_pc_plus8;
    logic        stall;
    logic        flush;
    logic        regWrite;
    logic [4:0]  rc;
    logic [31:0] dc;
    logic [4:0]  id_ra;
    logic [4:0]  id_rb;
    logic [31:0] id_da_raw;
    logic [31:0] id_db_raw;
    logic [31:0] id_da;
    logic [31:0] id_db;
    logic        wb_misaligned;
    logic [31:0] retire_cnt;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_wb_sel     (mem_wb_sel),
        .mem_ld_type    (mem_ld_type),
        .mem_pc_plus8   (mem_pc_plus8),
        .stall          (stall),
        .flush          (flush),
        .regWrite       (regWrite),
        .rc             (rc),
        .dc             (dc),
        .id_ra          (id_ra),
        .id_rb          (id_rb),
        .id_da_raw      (id_da_raw),
        .id_db_raw      (id_db_raw),
        .id_da          (id_da),
        .id_db          (id_db),
        .wb_misaligned  (wb_misaligned),
        .retire_cnt     (retire_cnt)
    );

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [1:0] sel, input logic [2:0] ld,
                         input logic st, input logic fl);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_rdata      = rdata;
        mem_wb_sel     = sel;
        mem_ld_type    = ld;
        mem_pc_plus8   = 32'h0000_1008;
        stall          = st;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
    endtask

    // Reference load behaviour from byte-addressed big-endian arithmetic.
    function automatic void ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                     input logic [2:0] ld, output logic [31:0] data,
                                     output logic mis);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * (3 - int'(off)))) & 32'hFF;
        h = (rdata >> (8 * (2 - int'(off[1] ? 2 : 0)))) & 32'hFFFF;
        mis  = 1'b0;
        data = rdata;
        case (ld)
            3'd1: begin mis = off[0]; data = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; end
            3'd2: begin mis = off[0]; data = h; end
            3'd3: data = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4: data = b;
            default: mis = (off != 2'd0);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        id_ra = 5'd0; id_rb = 5'd0;
        id_da_raw = 32'h1111_2222; id_db_raw = 32'h3333_4444;
        drive(1'b1, 1'b1, 5'd5, 32'h77, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'd5, 32'h77, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        if (regWrite !== 1'b0) begin $display("FAIL reset_regWrite got %0b want 0", regWrite); fails++; end
        tests++;
        if (rc !== 5'd0) begin $display("FAIL reset_rc got %0d want 0", rc); fails++; end
        tests++;
        if (dc !== 32'h0) begin $display("FAIL reset_dc got %h want 0", dc); fails++; end
        tests++;
        if (wb_misaligned !== 1'b0) begin $display("FAIL reset_mis got %0b want 0", wb_misaligned); fails++; end
        tests++;
        if (retire_cnt !== 32'h0) begin $display("FAIL reset_cnt got %0d want 0", retire_cnt); fails++; end
        tests++;
        if (id_da !== 32'h1111_2222) begin $display("FAIL reset_id_da got %h want 11112222", id_da); fails++; end
        tests++;
        rst = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 5'd8, 32'h0000_000A, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        if (regWrite !== 1'b1) begin $display("FAIL alu_regWrite got %0b want 1", regWrite); fails++; end
        tests++;
        if (rc !== 5'd8) begin $display("FAIL alu_rc got %0d want 8", rc); fails++; end
        tests++;
        if (dc !== 32'hA) begin $display("FAIL alu_dc got %h want 0000000a", dc); fails++; end
        tests++;
        exp_cnt++;
        bubble();
        if (retire_cnt !== exp_cnt) begin $display("FAIL alu_cnt got %0d want %0d", retire_cnt, exp_cnt); fails++; end
        tests++;
        // Link writeback and the unused select 11 (ALU).
        drive(1'b1, 1'b1, 5'd31, 32'h5555, 32'h0, 2'b10, 3'd0, 1'b0, 1'b0);
        if (dc !== 32'h0000_1008) begin $display("FAIL link_dc got %h want 00001008", dc); fails++; end
        tests++;
        drive(1'b1, 1'b1, 5'd9, 32'h5555, 32'h0, 2'b11, 3'd0, 1'b0, 1'b0);
        if (dc !== 32'h5555) begin $display("FAIL sel11_dc got %h want 00005555", dc); fails++; end
        tests++;
        exp_cnt += 2;
    endtask

    task automatic test_loads();
        logic [2:0]  lds  [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
        logic [1:0]  offs [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
        logic [31:0] exps [4] = '{32'hFFFF_FF99, 32'h0000_00BB, 32'hFFFF_AABB, 32'h0000_8899};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'd3, {30'h100, offs[i]}, 32'h8899_AABB, 2'b01, lds[i], 1'b0, 1'b0);
            if (dc !== exps[i] || regWrite !== 1'b1) begin
                $display("FAIL load_%0d got dc=%h we=%0b want dc=%h we=1", i, dc, regWrite, exps[i]);
                fails++;
            end
            tests++;
            exp_cnt++;
        end
        bubble();
        if (retire_cnt !== exp_cnt) begin $display("FAIL load_cnt got %0d want %0d", retire_cnt, exp_cnt); fails++; end
        tests++;
    endtask

    task automatic test_misaligned();
        logic [2:0] lds  [2] = '{3'd0, 3'd1};
        logic [1:0] offs [2] = '{2'd2, 2'd3};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 5'd4, {30'h200, offs[i]}, 32'h8899_AABB, 2'b01, lds[i], 1'b0, 1'b0);
            if (regWrite !== 1'b0 || wb_misaligned !== 1'b1) begin
                $display("FAIL misaligned_%0d got we=%0b mis=%0b want we=0 mis=1", i, regWrite, wb_misaligned);
                fails++;
            end
            tests++;
            bubble();
            if (wb_misaligned !== 1'b0) begin $display("FAIL mis_pulse_%0d got %0b want 0", i, wb_misaligned); fails++; end
            tests++;
            if (retire_cnt !== exp_cnt) begin $display("FAIL mis_cnt_%0d got %0d want %0d", i, retire_cnt, exp_cnt); fails++; end
            tests++;
        end
    endtask

    task automatic test_rd_zero();
        drive(1'b1, 1'b1, 5'd0, 32'h1234, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        if (regWrite !== 1'b0) begin $display("FAIL rd0_regWrite got %0b want 0", regWrite); fails++; end
        tests++;
        exp_cnt++;
        bubble();
        if (retire_cnt !== exp_cnt) begin $display("FAIL rd0_cnt got %0d want %0d", retire_cnt, exp_cnt); fails++; end
        tests++;
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd12, 32'h5, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        exp_cnt++;
        id_ra = 5'd12; id_da_raw = 32'h0;
        id_rb = 5'd13; id_db_raw = 32'hDEAD_BEEF;
        #1;
        if (id_da !== 32'h5) begin $display("FAIL bypass_da got %h want 00000005", id_da); fails++; end
        tests++;
        if (id_db !== 32'hDEAD_BEEF) begin $display("FAIL bypass_db got %h want deadbeef", id_db); fails++; end
        tests++;
        bubble();
        if (id_da !== 32'h0) begin $display("FAIL bypass_bubble_da got %h want 0", id_da); fails++; end
        tests++;
    endtask

    task automatic test_stall_flush();
        logic [1:0] sf [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd20, 32'h0000_0AAA + i, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
            exp_cnt++;
            drive(1'b1, 1'b1, 5'd21, 32'h0000_0BBB, 32'h0, 2'b00, 3'd0, sf[i][1], sf[i][0]);
            if (regWrite !== 1'b0) begin $display("FAIL stallflush_%0d_we got %0b want 0", i, regWrite); fails++; end
            tests++;
            if (rc !== 5'd20 || dc !== 32'h0000_0AAA + i) begin
                $display("FAIL stallflush_%0d_hold got rc=%0d dc=%h want rc=20 dc=%h", i, rc, dc, 32'h0000_0AAA + i);
                fails++;
            end
            tests++;
        end
        bubble();
        if (retire_cnt !== exp_cnt) begin $display("FAIL stallflush_cnt got %0d want %0d", retire_cnt, exp_cnt); fails++; end
        tests++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd7, 32'h99, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd6, 32'h98, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        if (regWrite !== 1'b0) begin $display("FAIL rstmid_we got %0b want 0", regWrite); fails++; end
        tests++;
        if (retire_cnt !== 32'h0) begin $display("FAIL rstmid_cnt got %0d want 0", retire_cnt); fails++; end
        tests++;
        bubble();
        if (retire_cnt !== 32'h0) begin $display("FAIL rstmid_cnt2 got %0d want 0", retire_cnt); fails++; end
        tests++;
    endtask

    task automatic test_random();
        logic        m_valid, m_rw, m_mis, m_known;
        logic [4:0]  m_rd;
        logic [31:0] m_dc, m_cnt, n_data, e_da, e_db;
        logic        n_mis, exp_we;
        logic        r_v, r_rw, r_st, r_fl, r_rst;
        logic [4:0]  r_rd;
        logic [31:0] r_alu, r_rdata;
        logic [1:0]  r_sel;
        logic [2:0]  r_ld;
        rst = 1'b1;
        bubble();
        rst = 1'b0;
        m_valid = 0; m_rw = 0; m_mis = 0; m_known = 1; m_rd = 0; m_dc = 0; m_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            r_rst   = ($urandom_range(0, 24) == 0);
            r_v     = ($urandom_range(0, 3) != 0);
            r_rw    = ($urandom_range(0, 4) != 0);
            r_rd    = 5'($urandom_range(0, 7));
            r_alu   = $urandom;
            r_rdata = $urandom;
            r_sel   = 2'($urandom_range(0, 3));
            r_ld    = 3'($urandom_range(0, 4));
            r_st    = ($urandom_range(0, 5) == 0);
            r_fl    = ($urandom_range(0, 5) == 0);
            id_ra     = 5'($urandom_range(0, 7));
            id_rb     = 5'($urandom_range(0, 7));
            id_da_raw = $urandom;
            id_db_raw = $urandom;
            ref_load(r_rdata, r_alu[1:0], r_ld, n_data, n_mis);
            if (r_sel == 2'b10) n_data = 32'h0000_1008;
            else if (r_sel != 2'b01) n_data = r_alu;
            rst = r_rst;
            drive(r_v, r_rw, r_rd, r_alu, r_rdata, r_sel, r_ld, r_st, r_fl);
            if (r_rst) begin
                m_valid = 0; m_rw = 0; m_mis = 0; m_known = 1; m_rd = 0; m_dc = 0; m_cnt = 0;
            end else begin
                if (m_valid && !m_mis) m_cnt = m_cnt + 1;
                if (r_v && !r_st && !r_fl) begin
                    m_valid = 1; m_rw = r_rw; m_rd = r_rd;
                    m_mis = (r_sel == 2'b01) && n_mis;
                    m_dc = n_data; m_known = !m_mis;
                end else begin
                    m_valid = 0; m_mis = 0;
                end
            end
            exp_we = m_valid && m_rw && (m_rd != 0) && !m_mis;
            e_da = (exp_we && m_rd == id_ra) ? m_dc : id_da_raw;
            e_db = (exp_we && m_rd == id_rb) ? m_dc : id_db_raw;
            if (regWrite !== exp_we) begin $display("FAIL rand_we cyc %0d got %0b want %0b", i, regWrite, exp_we); fails++; end
            tests++;
            if (rc !== m_rd) begin $display("FAIL rand_rc cyc %0d got %0d want %0d", i, rc, m_rd); fails++; end
            tests++;
            if (m_known) begin
                if (dc !== m_dc) begin $display("FAIL rand_dc cyc %0d got %h want %h", i, dc, m_dc); fails++; end
                tests++;
            end
            if (wb_misaligned !== m_mis) begin $display("FAIL rand_mis cyc %0d got %0b want %0b", i, wb_misaligned, m_mis); fails++; end
            tests++;
            if (retire_cnt !== m_cnt) begin $display("FAIL rand_cnt cyc %0d got %0d want %0d", i, retire_cnt, m_cnt); fails++; end
            tests++;
            if (id_da !== e_da || id_db !== e_db) begin
                $display("FAIL rand_bypass cyc %0d got %h/%h want %h/%h", i, id_da, id_db, e_da, e_db);
                fails++;
            end
            tests++;
        end
        rst = 1'b0;
    endtask

    initial begin
        exp_cnt = 32'd0;
        test_reset();
        test_alu();
        test_loads();
        test_misaligned();
        test_rd_zero();
        test_bypass();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
